// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states,
// register word offsets, CTRL bit positions and mode encodings.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int unsigned CTRL_W        = 4;
    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_MODE_MSB = 2;
    localparam int unsigned CTRL_IM       = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_counter_if.sv
// Bridge-side device port of the timer: word-addressed register access plus IRQ.
interface timer_counter_if;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;
    logic        IRQ;

    modport master (output Addr, output WD, output WE, input RD, input IRQ);
    modport slave  (input Addr, input WD, input WE, output RD, output IRQ);
endinterface

// File: rtl/timer_prescaler.sv
// Divide-by-DIV tick generator; restarts from zero on clear and only advances while enabled.
module timer_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit countdown timer with one-shot / auto-reload modes and masked IRQ.
// Define TIMER_PRESCALE_EN to gate each count step by a PRESCALE_DIV-cycle prescaler.
module timer_counter
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_7f00,
    parameter int unsigned PRESCALE_DIV = 4
) (
    input logic            clk,
    input logic            reset,
    timer_counter_if.slave bus
);
    state_t            state, state_next;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       preset;
    logic [31:0]       count;
    logic              irq_flag;
    logic              tick;

    logic [1:0] offset;
    logic       wr_ctrl, wr_preset;
    logic       en, reload;
    logic       load_count, dec_count, set_irq, clr_irq, clr_en;
    logic       unused_ok;

    assign offset    = bus.Addr[3:2];
    assign wr_ctrl   = bus.WE && (offset == OFF_CTRL);
    assign wr_preset = bus.WE && (offset == OFF_PRESET);
    assign en        = ctrl[CTRL_EN];
    assign reload    = (ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD);
    assign unused_ok = ^{bus.Addr[31:4], bus.Addr[1:0], BASE_ADDR, PRESCALE_DIV};

`ifdef TIMER_PRESCALE_EN
    timer_prescaler #(
        .DIV (PRESCALE_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (state == LOAD),
        .enable (state == CNT),
        .tick   (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (en) state_next = LOAD;
            LOAD: state_next = CNT;
            CNT: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (tick && (count <= 32'd1)) begin
                    state_next = INT;
                end
            end
            INT: state_next = reload ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_count = 1'b0;
        dec_count  = 1'b0;
        set_irq    = 1'b0;
        clr_irq    = 1'b0;
        clr_en     = 1'b0;
        unique case (state)
            LOAD: load_count = 1'b1;
            CNT: begin
                if (en && tick) begin
                    dec_count = (count != '0);
                    set_irq   = (count <= 32'd1);
                end
            end
            INT: begin
                clr_irq = reload;
                clr_en  = !reload;
            end
            default: ;
        endcase
    end

    // A CPU write to CTRL overrides the FSM's one-shot En clear on the same edge;
    // a terminal-count set of irq_flag beats a coincident CTRL-write acknowledge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= bus.WD[CTRL_W-1:0];
            end else if (clr_en) begin
                ctrl[CTRL_EN] <= 1'b0;
            end

            if (wr_preset) begin
                preset <= bus.WD;
            end

            if (load_count) begin
                count <= preset;
            end else if (dec_count) begin
                count <= count - 32'd1;
            end

            if (set_irq) begin
                irq_flag <= 1'b1;
            end else if (clr_irq || wr_ctrl) begin
                irq_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.RD = '0;
        unique case (offset)
            OFF_CTRL:   bus.RD = {28'd0, ctrl};
            OFF_PRESET: bus.RD = preset;
            OFF_COUNT:  bus.RD = count;
            default:    bus.RD = '0;
        endcase
    end

    assign bus.IRQ = irq_flag & ctrl[CTRL_IM];

endmodule
